l1_trigger_gen: RTL
===================

// Module: l1_trigger_gen
// PURPOSE
//  Transmit side of the L1 trigger line: turns soft/external trigger requests into clean
//  1-cycle high L1 pulses, each followed by a guaranteed low gap so the FE edge detector sees
//  one edge per trigger. Queues pending requests, expands each into a burst, honours FE
//  backpressure (Hold). Sits in the DAQ/emulator top, driving the FE L1 trigger input.
// PARAMETERS
//  CNT_W   4  width of Burst_Len, Gap and internal burst/gap counters
//  PEND_W  4  width of pending-request counter (saturates at 2**PEND_W-1)
//  MIN_GAP 2  minimum low cycles between pulses; must be >=1
// PORTS
//  Clk          in  1       single clock, all logic on posedge
//  Reset        in  1       asynchronous, active-high
//  Enable       in  1       1 = accept and issue triggers
//  Soft_Trig    in  1       synchronous request, 1 request per high cycle
//  Ext_Trig     in  1       asynchronous external trigger, 1 request per rising edge
//  Burst_Len    in  CNT_W   pulses per request; 0 treated as 1; sampled at burst start
//  Gap          in  CNT_W   low cycles after each pulse; clamped to >=MIN_GAP; sampled per pulse
//  Hold         in  1       FE busy/backpressure; no new pulse started while high
//  L1_Trig_Out  out 1       registered trigger pulse to FE
//  Busy         out 1       state!=IDLE or Pending!=0
//  Pending      out PEND_W  queued requests not yet started
//  Overflow     out 1       sticky: request dropped at saturation; cleared only by Reset
//  Sent_Count   out 16      total pulses issued, wraps 16'hFFFF->0
// BEHAVIOUR
//  - Reset: all outputs 0, state IDLE, counters 0, sync flops 0; takes effect immediately, incl. mid-pulse.
//  - Ext_Trig: 2-FF synchroniser + edge register; rising edge = 1 request, 3 cycles after the edge.
//  - Requests this cycle r = Soft_Trig + ext_edge (0..2), only when Enable=1; else ignored.
//  - Pending_next = min(Pending + r - d, 2**PEND_W-1), d=1 on IDLE->PULSE; any truncation sets Overflow.
//  - Enable=0: Pending cleared next cycle; pulse in progress completes; burst ends at end of current GAP.
//  - FSM IDLE/PULSE/GAP; L1_Trig_Out=1 exactly while state==PULSE (registered, glitch-free).
//    IDLE : Pending>0 & Enable & !Hold -> PULSE; load burst_rem=max(Burst_Len,1).
//    PULSE: 1 cycle; Sent_Count+1; burst_rem-1; load gap_cnt=max(Gap,MIN_GAP); -> GAP.
//    GAP  : gap_cnt-1 each cycle; at gap_cnt==1: burst_rem>0 & Enable & !Hold -> PULSE;
//           burst_rem>0 & Hold -> stay GAP (gap_cnt held at 1) until Hold=0;
//           burst_rem==0 or !Enable -> IDLE (burst_rem cleared).
//  - Latency: Soft_Trig high at edge n -> L1_Trig_Out high after edge n+1 (no Hold, IDLE).
//  - Pulse period within burst = 1+max(Gap,MIN_GAP); between bursts >= 1+MIN_GAP+1 (IDLE cycle).
//  - Hold never truncates a pulse; it only delays the next PULSE entry.
//  - Burst_Len/Gap changes mid-burst affect only next load point (burst start / next PULSE).
// CONFIGURATION
//  L1_TRIGGEN_TMR_EN defined: state, burst_rem, gap_cnt, Pending and L1_Trig_Out held in 3 copies,
//    each reloaded from the 2-of-3 majority vote every cycle; outputs driven from voted values.
//    A single upset copy is corrected next cycle, no output disturbance.
//  Not defined: single-copy registers; identical cycle behaviour and latency.
// TESTING
//  1 Soft_Trig 1 cycle, Burst_Len=3, Gap=4 -> 3 pulses of 1 cycle, rising edges 5 cycles apart,
//    first high 2 edges after request; Sent_Count=3; Busy=0 after last gap + 1.
//  2 Gap=0, MIN_GAP=2, Burst_Len=2 -> pulse period 3; Burst_Len=0 -> exactly 1 pulse.
//  3 Hold=1, 17 Soft_Trig cycles, PEND_W=4 -> Pending=15, Overflow=1; drop Hold ->
//    15 single-pulse bursts, Pending=0, Overflow stays 1.
//  4 Hold rises during GAP of Burst_Len=4 -> output stays 0 while Hold=1; first pulse
//    1 cycle after Hold falls; total 4 pulses.
//  5 Soft_Trig + Ext_Trig edge landing same cycle as IDLE->PULSE with Pending=1 ->
//    Pending=2 next cycle; Enable=0 mid-burst -> current pulse completes, no further pulses.
//  6 Reset during PULSE -> L1_Trig_Out=0 without clock edge; all outputs 0; with
//    L1_TRIGGEN_TMR_EN, force one copy of state to PULSE in IDLE -> no output pulse.

Source files
------------

// File: rtl/l1_trigger_gen.sv
// L1 trigger transmitter: queues soft/external requests and emits 1-cycle pulses with guaranteed low gaps.
// Define L1_TRIGGEN_TMR_EN to triplicate the FSM/pending/output registers with majority voting.
module l1_trigger_gen #(
  parameter int CNT_W   = 4,
  parameter int PEND_W  = 4,
  parameter int MIN_GAP = 2
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              Enable,
  input  logic              Soft_Trig,
  input  logic              Ext_Trig,
  input  logic [CNT_W-1:0]  Burst_Len,
  input  logic [CNT_W-1:0]  Gap,
  input  logic              Hold,
  output logic              L1_Trig_Out,
  output logic              Busy,
  output logic [PEND_W-1:0] Pending,
  output logic              Overflow,
  output logic [15:0]       Sent_Count
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PULSE = 2'd1,
    GAP   = 2'd2
  } state_t;

  localparam logic [PEND_W-1:0] PEND_MAX  = '1;
  localparam logic [CNT_W-1:0]  MIN_GAP_C = CNT_W'(MIN_GAP);
  localparam logic [CNT_W-1:0]  ONE_C     = CNT_W'(1);

  // voted (or single-copy) register values and their next-state values
  state_t              state_v, state_n;
  logic [CNT_W-1:0]    burst_v, burst_n;
  logic [CNT_W-1:0]    gap_v, gap_n;
  logic [PEND_W-1:0]   pend_v, pend_n;
  logic                l1_v, l1_n;
  logic                start;
  logic                ovf_set;
  logic [PEND_W+1:0]   sum;

  logic ext_s1, ext_s2, ext_s3, ext_edge;

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      ext_s1   <= 1'b0;
      ext_s2   <= 1'b0;
      ext_s3   <= 1'b0;
      ext_edge <= 1'b0;
    end else begin
      ext_s1   <= Ext_Trig;
      ext_s2   <= ext_s1;
      ext_s3   <= ext_s2;
      ext_edge <= ext_s2 & ~ext_s3;
    end
  end

  always_comb begin
    state_n = state_v;
    burst_n = burst_v;
    gap_n   = gap_v;
    start   = 1'b0;
    case (state_v)
      IDLE: begin
        if (pend_v != '0 && Enable && !Hold) begin
          state_n = PULSE;
          burst_n = (Burst_Len == '0) ? ONE_C : Burst_Len;
          start   = 1'b1;
        end
      end
      PULSE: begin
        state_n = GAP;
        burst_n = burst_v - ONE_C;
        gap_n   = (Gap < MIN_GAP_C) ? MIN_GAP_C : Gap;
      end
      GAP: begin
        if (gap_v > ONE_C) begin
          gap_n = gap_v - ONE_C;
        end else if (burst_v == '0 || !Enable) begin
          state_n = IDLE;
          burst_n = '0;
          gap_n   = '0;
        end else if (!Hold) begin
          state_n = PULSE;
        end
        // Hold with burst remaining: stay here with gap_cnt parked at 1
      end
      default: begin
        state_n = IDLE;
        burst_n = '0;
        gap_n   = '0;
      end
    endcase
  end

  always_comb begin
    pend_n  = pend_v;
    ovf_set = 1'b0;
    sum     = (PEND_W+2)'(pend_v)
            + (PEND_W+2)'(Soft_Trig)
            + (PEND_W+2)'(ext_edge)
            - (PEND_W+2)'(start);
    if (!Enable) begin
      pend_n = '0;
    end else if (sum > (PEND_W+2)'(PEND_MAX)) begin
      pend_n  = PEND_MAX;
      ovf_set = 1'b1;
    end else begin
      pend_n = sum[PEND_W-1:0];
    end
  end

  assign l1_n = (state_n == PULSE);

`ifdef L1_TRIGGEN_TMR_EN
  logic [1:0]        state_r [3];
  logic [CNT_W-1:0]  burst_r [3];
  logic [CNT_W-1:0]  gap_r   [3];
  logic [PEND_W-1:0] pend_r  [3];
  logic [2:0]        l1_r;

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      for (int i = 0; i < 3; i++) begin
        state_r[i] <= IDLE;
        burst_r[i] <= '0;
        gap_r[i]   <= '0;
        pend_r[i]  <= '0;
      end
      l1_r <= '0;
    end else begin
      // every copy reloads from the voted next value, scrubbing single upsets
      for (int i = 0; i < 3; i++) begin
        state_r[i] <= state_n;
        burst_r[i] <= burst_n;
        gap_r[i]   <= gap_n;
        pend_r[i]  <= pend_n;
      end
      l1_r <= {3{l1_n}};
    end
  end

  assign state_v = state_t'((state_r[0] & state_r[1]) | (state_r[0] & state_r[2]) | (state_r[1] & state_r[2]));
  assign burst_v = (burst_r[0] & burst_r[1]) | (burst_r[0] & burst_r[2]) | (burst_r[1] & burst_r[2]);
  assign gap_v   = (gap_r[0] & gap_r[1]) | (gap_r[0] & gap_r[2]) | (gap_r[1] & gap_r[2]);
  assign pend_v  = (pend_r[0] & pend_r[1]) | (pend_r[0] & pend_r[2]) | (pend_r[1] & pend_r[2]);
  assign l1_v    = (l1_r[0] & l1_r[1]) | (l1_r[0] & l1_r[2]) | (l1_r[1] & l1_r[2]);
`else
  state_t            state_q;
  logic [CNT_W-1:0]  burst_q;
  logic [CNT_W-1:0]  gap_q;
  logic [PEND_W-1:0] pend_q;
  logic              l1_q;

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q <= IDLE;
      burst_q <= '0;
      gap_q   <= '0;
      pend_q  <= '0;
      l1_q    <= 1'b0;
    end else begin
      state_q <= state_n;
      burst_q <= burst_n;
      gap_q   <= gap_n;
      pend_q  <= pend_n;
      l1_q    <= l1_n;
    end
  end

  assign state_v = state_q;
  assign burst_v = burst_q;
  assign gap_v   = gap_q;
  assign pend_v  = pend_q;
  assign l1_v    = l1_q;
`endif

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      Overflow   <= 1'b0;
      Sent_Count <= '0;
    end else begin
      Overflow <= Overflow | ovf_set;
      if (state_v == PULSE) Sent_Count <= Sent_Count + 16'd1;
    end
  end

  assign L1_Trig_Out = l1_v;
  assign Pending     = pend_v;
  assign Busy        = (state_v != IDLE) || (pend_v != '0);

endmodule
